// File: rtl/mem_ss_pkg.sv
// mem_ss_pkg: shared write-FSM states and error-bit indices for the memory subsystem.
package mem_ss_pkg;

    typedef enum logic {
        IDLE,
        WR_BURST
    } wr_state_e;

    localparam int ERR_UNDERFLOW  = 0;
    localparam int ERR_ZERO_BURST = 1;

endpackage

// File: rtl/mem_rd_pending_limiter_if.sv
// mem_rd_pending_limiter_if: Avalon-MM bus bundle with master and slave views.
interface mem_rd_pending_limiter_if #(
    parameter int DATA_WIDTH       = 512,
    parameter int SYMBOL_WIDTH     = 8,
    parameter int RESPONSE_WIDTH   = 2,
    parameter int HDL_ADDR_WIDTH   = 27,
    parameter int BURSTCOUNT_WIDTH = 7
);

    localparam int BYTEEN_WIDTH = DATA_WIDTH / SYMBOL_WIDTH;

    logic                        waitrequest;
    logic                        read;
    logic                        write;
    logic                        debugaccess;
    logic [HDL_ADDR_WIDTH-1:0]   address;
    logic [BURSTCOUNT_WIDTH-1:0] burstcount;
    logic [DATA_WIDTH-1:0]       writedata;
    logic [BYTEEN_WIDTH-1:0]     byteenable;
    logic [DATA_WIDTH-1:0]       readdata;
    logic                        readdatavalid;
    logic [RESPONSE_WIDTH-1:0]   response;

    modport master (
        input  waitrequest, readdata, readdatavalid, response,
        output read, write, debugaccess, address, burstcount, writedata, byteenable
    );

    modport slave (
        output waitrequest, readdata, readdatavalid, response,
        input  read, write, debugaccess, address, burstcount, writedata, byteenable
    );

endinterface

// File: rtl/mem_rd_pending_limiter.sv
// mem_rd_pending_limiter: bounds in-flight read beats, holds reads off during write
// bursts and registers the read-response path by one stage.
module mem_rd_pending_limiter
    import mem_ss_pkg::*;
#(
    parameter int DATA_WIDTH        = 512,
    parameter int SYMBOL_WIDTH      = 8,
    parameter int RESPONSE_WIDTH    = 2,
    parameter int HDL_ADDR_WIDTH    = 27,
    parameter int BURSTCOUNT_WIDTH  = 7,
    parameter int MAX_PENDING_BEATS = 128,
    localparam int BYTEEN_WIDTH     = DATA_WIDTH / SYMBOL_WIDTH,
    localparam int CNT_WIDTH        = $clog2(MAX_PENDING_BEATS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    mem_rd_pending_limiter_if.slave    s0,
    mem_rd_pending_limiter_if.master   m0,
    output logic [CNT_WIDTH-1:0]       pending_beats,
    output logic [1:0]                 err_sticky
);

    localparam logic [BURSTCOUNT_WIDTH-1:0] BC_ONE  = BURSTCOUNT_WIDTH'(1);
    localparam logic [CNT_WIDTH:0]          LIMIT   = (CNT_WIDTH + 1)'(MAX_PENDING_BEATS);

    wr_state_e                   state, state_nx;
    logic [BURSTCOUNT_WIDTH-1:0] wr_left, wr_left_nx;
    logic [CNT_WIDTH-1:0]        pending, pending_nx;
    logic [1:0]                  err_nx;
    logic [CNT_WIDTH:0]          rd_sum;
    logic                        rd_block, rd_acc, wr_acc, underflow, ret, zero_burst;
    logic [HDL_ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH-1:0]       writedata;
    logic [BYTEEN_WIDTH-1:0]     byteenable;
    logic [DATA_WIDTH-1:0]       rdata_q;
    logic [RESPONSE_WIDTH-1:0]   resp_q;
    logic                        rvalid_q;

    assign address       = s0.address;
    assign writedata     = s0.writedata;
    assign byteenable    = s0.byteenable;
    assign m0.address    = address;
    assign m0.writedata  = writedata;
    assign m0.byteenable = byteenable;
    assign m0.burstcount = s0.burstcount;
    assign m0.debugaccess = s0.debugaccess;

    // One extra bit on the sum keeps pending + a maximal burst from wrapping.
    assign rd_sum   = {1'b0, pending} + (CNT_WIDTH + 1)'(s0.burstcount);
    assign rd_block = (state == WR_BURST) | (rd_sum > LIMIT);

    assign m0.read        = s0.read & ~rd_block & ~reset;
    assign m0.write       = s0.write & ~reset;
    assign s0.waitrequest = m0.waitrequest | (s0.read & rd_block) | reset;

    assign rd_acc     = m0.read & ~m0.waitrequest;
    assign wr_acc     = m0.write & ~m0.waitrequest;
    assign underflow  = m0.readdatavalid & (pending == '0);
    assign ret        = m0.readdatavalid & ~underflow;
    assign zero_burst = (rd_acc | (wr_acc & (state == IDLE))) & (s0.burstcount == '0);

    always_comb begin
        pending_nx = pending + (rd_acc ? CNT_WIDTH'(s0.burstcount) : '0) - CNT_WIDTH'(ret);
        err_nx = err_sticky;
        err_nx[ERR_UNDERFLOW]  = err_sticky[ERR_UNDERFLOW] | underflow;
        err_nx[ERR_ZERO_BURST] = err_sticky[ERR_ZERO_BURST] | zero_burst;
    end

    // Only the first beat's burstcount matters; later beats just count down.
    always_comb begin
        state_nx   = state;
        wr_left_nx = wr_left;
        if (wr_acc && state == IDLE && s0.burstcount > BC_ONE) begin
            state_nx   = WR_BURST;
            wr_left_nx = s0.burstcount - BC_ONE;
        end else if (wr_acc && state == WR_BURST) begin
            wr_left_nx = wr_left - BC_ONE;
            state_nx   = (wr_left == BC_ONE) ? IDLE : WR_BURST;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_left    <= '0;
            pending    <= '0;
            err_sticky <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state      <= state_nx;
            wr_left    <= wr_left_nx;
            pending    <= pending_nx;
            err_sticky <= err_nx;
            rvalid_q   <= m0.readdatavalid;
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= m0.readdata;
        resp_q  <= m0.response;
    end

    assign s0.readdata      = rdata_q;
    assign s0.response      = resp_q;
    assign s0.readdatavalid = rvalid_q;
    assign pending_beats    = pending;

endmodule

// File: doc/mem_rd_pending_limiter.md
# mem_rd_pending_limiter

Avalon-MM flow-control stage between the local-memory client port and the memory-subsystem pipeline bridge. It counts in-flight read beats and stalls new read commands whose full burst would exceed `MAX_PENDING_BEATS`, bounding the response buffering required upstream. It tracks write bursts so that no read is accepted in the middle of a write burst. It also registers the read-response path by one stage.

## Interface
**Parameters**
- `DATA_WIDTH`, default 512: data width.
- `SYMBOL_WIDTH`, default 8: byte width.
- `RESPONSE_WIDTH`, default 2: response width.
- `HDL_ADDR_WIDTH`, default 27: word address width.
- `BURSTCOUNT_WIDTH`, default 7: burstcount width.
- `MAX_PENDING_BEATS`, default 128: limit on outstanding read beats. Must be ≥ 2^(BURSTCOUNT_WIDTH-1).
- `BYTEEN_WIDTH`, derived: `DATA_WIDTH/SYMBOL_WIDTH`.
- `CNT_WIDTH`, derived: `$clog2(MAX_PENDING_BEATS+1)`.

**Ports**
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `s0_waitrequest`, out, 1: stall to the upstream master.
- `s0_read`, `s0_write`, `s0_debugaccess`, in, 1 each: command.
- `s0_address`, in, `HDL_ADDR_WIDTH`: address.
- `s0_burstcount`, in, `BURSTCOUNT_WIDTH`: burst length.
- `s0_writedata`, in, `DATA_WIDTH`: write data.
- `s0_byteenable`, in, `BYTEEN_WIDTH`: byte enables.
- `s0_readdata`, out, `DATA_WIDTH`: registered read data.
- `s0_readdatavalid`, out, 1: registered read data valid.
- `s0_response`, out, `RESPONSE_WIDTH`: registered response.
- `m0_*`, mirror of `s0_*` with directions reversed: toward the pipeline bridge.
- `pending_beats`, out, `CNT_WIDTH`: current outstanding read-beat count.
- `err_sticky`, out, 2: bit0 = count underflow, bit1 = zero burstcount. Sticky until reset.

## Operation
- **Command path (combinational).** Address, data, byteenable, burstcount and debugaccess pass straight through.
  - `m0_read = s0_read & ~rd_block & ~reset`.
  - `m0_write = s0_write & ~reset`.
  - `s0_waitrequest = m0_waitrequest | (s0_read & rd_block) | reset`.
- **Read block.** `rd_block = (state==WR_BURST) | (pending + s0_burstcount > MAX_PENDING_BEATS)`.
  - The comparison uses a `CNT_WIDTH+1`-bit sum, so it cannot overflow.
  - `rd_block` depends only on registered state and current `s0` inputs.
- **Read accept.** `rd_acc = m0_read & ~m0_waitrequest`.
  - Increment `pending` by `s0_burstcount` on `rd_acc`.
  - Decrement `pending` by 1 on each `m0_readdatavalid`.
  - Both events in the same cycle: `pending <= pending + burstcount - 1`, applied as a single update.
- **Underflow.** `m0_readdatavalid` while `pending == 0`: `pending` stays 0 and `err_sticky[0]` is set.
- **Zero burstcount.** An accepted command with `burstcount == 0` is forwarded and counted as 0 beats; `err_sticky[1]` is set.
- **Write FSM.** States `IDLE` and `WR_BURST`; `wr_left` is a `BURSTCOUNT_WIDTH`-bit counter.
  - `wr_acc = m0_write & ~m0_waitrequest`.
  - `IDLE`, `wr_acc` with `burstcount > 1`: go to `WR_BURST`, `wr_left <= burstcount - 1`.
  - `IDLE`, `wr_acc` with `burstcount == 1`: stay in `IDLE`.
  - `WR_BURST`, `wr_acc`: `wr_left` decrements; return to `IDLE` when `wr_left == 1`.
  - Burstcount on beats after the first is ignored.
- **Response path.** One register stage: `s0_readdata`, `s0_response` and `s0_readdatavalid` equal the `m0_*` values delayed one cycle.
- **Reset (synchronous, applied at the clock edge).**
  - `pending = 0`, `state = IDLE`, `wr_left = 0`, `err_sticky = 0`, `s0_readdatavalid = 0`.
  - `s0_readdata` and `s0_response` are not reset.
  - While `reset` is high: `s0_waitrequest = 1`, `m0_read = m0_write = 0`.
- **Reset mid-operation.** Counts are discarded. Responses that arrive after reset are treated as underflows and flagged.

## Timing
- Command latency: 0 cycles, combinational.
- Response latency: 1 cycle.
- `pending_beats` reflects a `rd_acc` or return on the cycle after the event.
- Read throughput: a single-beat read issued every cycle is sustained while `pending + 1 ≤ MAX_PENDING_BEATS`.
- A stalled read holds `s0_waitrequest` high until enough returns arrive to clear `rd_block`. Per Avalon rules, the upstream master must keep its command stable during the stall.
- Boundary: `pending == MAX_PENDING_BEATS` with a return in the same cycle does not admit a read that cycle; the read is admitted next cycle.

## Structure
- Shared package `mem_ss_pkg`: `wr_state_e` (`IDLE`, `WR_BURST`) and the error-bit index constants `ERR_UNDERFLOW = 0`, `ERR_ZERO_BURST = 1`.
- No sub-modules. The counter, FSM and response register live in one module of roughly 150–200 lines.

## Test plan
- **Fill to limit.** `MAX=128`, issue two bursts of 64 with no returns; a third read of burstcount 1 is stalled → `s0_waitrequest = 1`, `pending_beats = 128`. After one return, the read is accepted and `pending_beats` returns to 128.
- **Simultaneous accept and return.** Accept a burst of 8 while a return arrives in the same cycle, starting from `pending = 5` → `pending = 12` next cycle.
- **Read held off during write burst.** Write burst of 4, with `s0_read` asserted after beat 2 → read not forwarded until the cycle after beat 4; the FSM is in `IDLE` at acceptance.
- **Response delay.** `m0_readdatavalid` pulses with `readdata = 0xA5…` → `s0_readdatavalid` and data appear exactly 1 cycle later; `pending` decrements by 1.
- **Error flags.** Return with `pending = 0` → `err_sticky = 2'b01`, `pending` stays 0. Then an accepted read with `burstcount = 0` → `err_sticky = 2'b11`.
- **Reset mid-burst.** `pending = 40` and `WR_BURST` active, assert `reset` for 1 cycle → `pending = 0`, `IDLE`, `s0_waitrequest = 1` during reset, `m0_read = m0_write = 0`.
